// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: register-index width,
// operand-forwarding select encodings, stall counter width and the shadow
// stage record that follows an instruction through EX and MEM.
package pipe_pkg;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 16;
  localparam int NUM_SRC = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Operand source selects presented to the ID stage
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF       = 2'b00;  // register file
  localparam fwd_sel_t FWD_EX_ALU   = 2'b01;  // EX ALU result
  localparam fwd_sel_t FWD_MEM_ALU  = 2'b10;  // MEM ALU result
  localparam fwd_sel_t FWD_MEM_LOAD = 2'b11;  // MEM load data

  // Write-back related fields of an instruction held in a later stage
  typedef struct packed {
    logic             wreg;
    logic             m2reg;
    logic [REG_W-1:0] rn;
  } stage_t;

  // A stage produces a source only if it writes a nonzero register that the
  // source actually reads; register 0 is hardwired and never produced.
  function automatic logic stage_hit(input stage_t stg,
                                     input logic use_src,
                                     input logic [REG_W-1:0] src);
    return use_src && stg.wreg && (stg.rn != '0) && (stg.rn == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID stage / control unit and the hazard controller.
// master: the pipeline side that issues the ID instruction and consumes the
// forwarding selects and stall controls; slave: the hazard controller.
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic             id_m2reg;
  logic [REG_W-1:0] id_rn;
  logic             ext_hold;
  logic             cnt_clr;
  fwd_sel_t         fwda;
  fwd_sel_t         fwdb;
  logic             wpcir;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output id_wreg, id_m2reg, id_rn,
    output ext_hold, cnt_clr,
    input  fwda, fwdb, wpcir, bubble, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_wreg, id_m2reg, id_rn,
    input  ext_hold, cnt_clr,
    output fwda, fwdb, wpcir, bubble, stall_cnt
  );

endinterface

// File: rtl/hazard_match.sv
// Per-source dependency resolver. Compares one ID source against the EX and
// MEM shadow stages and returns the forwarding select and a stall request.
// Build option: HAZARD_FWD_EN -- when defined, producers are forwarded with
// EX taking priority over MEM and only an EX load stalls; when undefined,
// the select stays on the register file and any EX/MEM producer stalls.
module hazard_match
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  stage_t           ex_stage,
  input  stage_t           mem_stage,
  output fwd_sel_t         sel,
  output logic             stall
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = stage_hit(ex_stage,  use_src, src);
  assign mem_hit = stage_hit(mem_stage, use_src, src);

`ifdef HAZARD_FWD_EN
  // Priority resolve: newest producer wins; a load still in EX has no data yet
  always_comb begin
    sel   = FWD_RF;
    stall = 1'b0;
    if (ex_hit && !ex_stage.m2reg) begin
      sel = FWD_EX_ALU;
    end else if (ex_hit) begin
      stall = 1'b1;
    end else if (mem_hit && !mem_stage.m2reg) begin
      sel = FWD_MEM_ALU;
    end else if (mem_hit) begin
      sel = FWD_MEM_LOAD;
    end
  end
`else
  // Load flags are irrelevant without forwarding paths
  logic unused_m2reg;
  assign unused_m2reg = ex_stage.m2reg ^ mem_stage.m2reg;

  // No bypass network: wait until the producer has reached WB
  always_comb begin
    sel   = FWD_RF;
    stall = ex_hit || mem_hit;
  end
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline data-hazard controller for a 5-stage in-order pipeline.
// Tracks the write-back fields of the instructions in EX and MEM, decides per
// ID source whether to read the register file, forward, or stall, and counts
// hazard-stall cycles in a saturating counter. WB producers need no handling
// because the register file is written before it is read in ID.
// Build option: HAZARD_FWD_EN enables the forwarding network (see
// hazard_match); the default build stalls on every EX/MEM dependency.
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  pipe_hazard_ctrl_if.slave hz
);

  stage_t ex_reg;
  stage_t mem_reg;
  stage_t id_stage;
  stage_t ex_next;

  logic [NUM_SRC-1:0][REG_W-1:0] src_vec;
  logic [NUM_SRC-1:0]            use_vec;
  logic [NUM_SRC-1:0][1:0]       sel_vec;
  logic [NUM_SRC-1:0]            stall_vec;

  logic             hazard;
  logic             stall_event;
  fwd_sel_t         fwda_c;
  fwd_sel_t         fwdb_c;
  logic             wpcir_c;
  logic             bubble_c;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign src_vec[0] = hz.id_rs;
  assign src_vec[1] = hz.id_rt;
  assign use_vec[0] = hz.id_use_rs;
  assign use_vec[1] = hz.id_use_rt;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      hazard_match u_match (
        .src       (src_vec[gi]),
        .use_src   (use_vec[gi]),
        .ex_stage  (ex_reg),
        .mem_stage (mem_reg),
        .sel       (sel_vec[gi]),
        .stall     (stall_vec[gi])
      );
    end
  endgenerate

  assign hazard = |stall_vec;

  assign id_stage.wreg  = hz.id_wreg;
  assign id_stage.m2reg = hz.id_m2reg;
  assign id_stage.rn    = hz.id_rn;

  // Pipeline control: reset forces idle outputs, an external hold freezes the
  // front end without injecting a bubble, otherwise a hazard stalls + bubbles
  always_comb begin
    fwda_c   = sel_vec[0];
    fwdb_c   = sel_vec[1];
    wpcir_c  = 1'b1;
    bubble_c = 1'b0;
    if (!resetn) begin
      fwda_c = FWD_RF;
      fwdb_c = FWD_RF;
    end else if (hz.ext_hold) begin
      wpcir_c = 1'b0;
    end else if (hazard) begin
      wpcir_c  = 1'b0;
      bubble_c = 1'b1;
    end
  end

  // A bubble enters EX with its write enable cleared; the whole record is
  // zeroed so a stale rn can never match later.
  assign ex_next = bubble_c ? '0 : id_stage;

  assign stall_event = resetn && !hz.ext_hold && hazard;

  // Clear beats increment; the count sticks at all-ones instead of wrapping
  assign cnt_next = hz.cnt_clr                          ? '0 :
                    (stall_event && (cnt_reg != CNT_MAX)) ? cnt_reg + CNT_W'(1) :
                                                            cnt_reg;

  // Shadow stages advance every edge unless the external hold freezes them
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_reg  <= '0;
      mem_reg <= '0;
    end else if (!hz.ext_hold) begin
      ex_reg  <= ex_next;
      mem_reg <= ex_reg;
    end
  end

  // Stall cycle counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign hz.fwda      = fwda_c;
  assign hz.fwdb      = fwdb_c;
  assign hz.wpcir     = wpcir_c;
  assign hz.bubble    = bubble_c;
  assign hz.stall_cnt = cnt_reg;

endmodule
